// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end.
// Used by the scan controller and by the downstream segment register.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE       = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_SEND         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } scan_state_t;

    localparam logic [3:0] COLS_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE  = 4'b1111;

    // True when exactly one of the active-low row lines is pulled low.
    function automatic logic is_onehot_low(input logic [3:0] rows);
        logic [3:0] low;
        low = ~rows;
        return (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/kp_counter.sv
// Up-counter with synchronous clear and increment enable.
// Also compares the current count against a runtime terminal value.
module kp_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             hit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == limit);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner for the 4x4 keypad. It debounces press and release and
// issues one write strobe per accepted key.
//
//   state           | meaning
//   ----------------+-----------------------------------------------------
//   ST_SETTLE       | column driven; rows are sampled on the last count
//   ST_DEBOUNCE     | rows must match row_lat for DEBOUNCE_CYCLES cycles
//   ST_SEND         | one-cycle WE_send with the pressed column still driven
//   ST_WAIT_RELEASE | column held until rows are idle for DEBOUNCE_CYCLES
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] synchrows,
    output logic [3:0] cols,
    output logic       WE_send,
    output logic       key_held
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LIM   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_t      state, next_state;
    logic [3:0]       cols_next;
    logic [3:0]       row_lat, row_lat_next;
    logic             cnt_clr, cnt_inc, cnt_hit;
    logic [CNT_W-1:0] cnt_limit;
    logic [CNT_W-1:0] cnt_value;
    logic             key_held_next;

    kp_counter #(
        .WIDTH (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_limit),
        .count (cnt_value),
        .hit   (cnt_hit)
    );

    always_comb begin
        next_state   = state;
        cols_next    = cols;
        row_lat_next = row_lat;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_limit    = SETTLE_LIM;
        case (state)
            ST_SETTLE: begin
                cnt_inc = 1'b1;
                if (cnt_hit) begin
                    cnt_clr = 1'b1;
                    if (synchrows == ROWS_IDLE) begin
                        cols_next = {cols[2:0], cols[3]};
                    end else if (is_onehot_low(synchrows)) begin
                        row_lat_next = synchrows;
                        next_state   = ST_DEBOUNCE;
                    end else begin
                        next_state = ST_WAIT_RELEASE;
                    end
                end
            end
            ST_DEBOUNCE: begin
                cnt_limit = DEBOUNCE_LIM;
                if (synchrows != row_lat) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_SETTLE;
                end else if (cnt_hit) begin
                    cnt_clr    = 1'b1;
                    next_state = ST_SEND;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_SEND: begin
                cnt_clr    = 1'b1;
                next_state = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                cnt_limit = DEBOUNCE_LIM;
                if (synchrows != ROWS_IDLE) begin
                    cnt_clr = 1'b1;
                end else if (cnt_hit) begin
                    cnt_clr    = 1'b1;
                    cols_next  = {cols[2:0], cols[3]};
                    next_state = ST_SETTLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                next_state = ST_SETTLE;
            end
        endcase
    end

    // key_held doubles as the chord flag: a chord enters WAIT_RELEASE with it low.
    assign key_held_next = (next_state == ST_SEND) ||
                           ((next_state == ST_WAIT_RELEASE) && ((state == ST_SEND) || key_held));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_SETTLE;
            cols     <= COLS_RESET;
            row_lat  <= ROWS_IDLE;
            WE_send  <= 1'b0;
            key_held <= 1'b0;
        end else begin
            state    <= next_state;
            cols     <= cols_next;
            row_lat  <= row_lat_next;
            WE_send  <= (next_state == ST_SEND);
            key_held <= key_held_next;
        end
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

- Sequencer for the 4x4 keypad front end.
- Drives one keypad column low at a time and watches the synchronized row lines.
- On a press, debounces it and issues a single-cycle `WE_send` strobe. During the strobe, `cols` still drives the pressed column and `synchrows` shows the pressed row, so the downstream two-digit segment register (`seg_ff`) captures exactly one code per physical press.
- After a press it holds the column until the key is debounced as released, so held keys and extra simultaneous keys never produce repeat writes.

## Interface
- `SETTLE_CYCLES`, default 16: cycles each column is driven before rows are sampled; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 200000: consecutive stable cycles required for both press and release; must be ≥ 1.
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `synchrows`  in  4  row lines, already synchronized, active-low (4'b1111 = no key).
- `cols`  out  4  column drive, one-hot-low, registered.
- `WE_send`  out  1  write strobe to `seg_ff`, registered, one cycle per accepted press.
- `key_held`  out  1  high from the strobe cycle until release is debounced.

## Operation
- States: SETTLE, DEBOUNCE, SEND, WAIT_RELEASE.
- A single counter of width $clog2(max(SETTLE_CYCLES, DEBOUNCE_CYCLES)+1) clears on every state entry.
- SETTLE
  - Counter increments every cycle; the sample cycle is the one where count == SETTLE_CYCLES-1.
  - If synchrows == 4'b1111 in the sample cycle: rotate `cols` left by one (1110→1101→1011→0111→1110) and re-enter SETTLE.
  - If synchrows is one-hot-low: latch it as `row_lat` and go to DEBOUNCE.
  - If more than one row is low: go to WAIT_RELEASE with no strobe (invalid chord).
- DEBOUNCE
  - Each cycle with synchrows == row_lat increments the counter.
  - At count == DEBOUNCE_CYCLES-1 with a match: go to SEND.
  - Any mismatch: return to SETTLE on the same column, counter cleared.
- SEND: exactly one cycle; `WE_send` = 1, `cols` unchanged; always goes to WAIT_RELEASE.
- WAIT_RELEASE
  - `cols` is held.
  - The counter increments while synchrows == 4'b1111 and clears on any low row.
  - At count == DEBOUNCE_CYCLES-1 with all rows high: rotate `cols` and go to SETTLE.
- Keys pressed on other columns while the block is in WAIT_RELEASE are invisible because their columns are not driven. They are detected only after release, on a later scan pass.
- `key_held` = 1 in SEND and WAIT_RELEASE only.
- Invalid-chord WAIT_RELEASE entries leave `key_held` = 0; a state flag or a separate encoding distinguishes them.

## Timing
- Reset values, applied asynchronously on `reset` rising, mid-operation included:
  - state = SETTLE, counter = 0, cols = 4'b1110, WE_send = 0, key_held = 0, row_lat = 4'b1111.
- First sample after reset deasserts: SETTLE_CYCLES cycles later.
- Column dwell with no key pressed: exactly SETTLE_CYCLES cycles; full scan period = 4·SETTLE_CYCLES.
- Press latency: sample cycle t, DEBOUNCE occupies t+1 … t+DEBOUNCE_CYCLES, `WE_send` is high in cycle t+DEBOUNCE_CYCLES+1.
- Release: the last of DEBOUNCE_CYCLES consecutive all-high cycles is cycle r; `cols` rotates at the edge ending cycle r, and the next column is driven in cycle r+1.
- `WE_send` is never high in two consecutive cycles. Minimum spacing between strobes is 2·DEBOUNCE_CYCLES + SETTLE_CYCLES + 1 cycles.
- All outputs are Moore (state-registered); there is no combinational path from `synchrows` to any output.

## Structure
- Package `keypad_pkg` holds:
  - state enum `scan_state_t`
  - `COLS_RESET` = 4'b1110
  - `ROWS_IDLE` = 4'b1111
  - function `is_onehot_low(logic [3:0])`
  - this package is shared with `seg_ff` and the top level.
- One sub-module, `kp_counter`: parameterized-width counter with `clr` and `inc`, plus terminal-compare output `hit` for a runtime `limit` input.
- FSM, column rotator and `row_lat` live in `keypad_scan_ctrl`.

## Test plan
All scenarios use SETTLE_CYCLES=2, DEBOUNCE_CYCLES=4.
- Reset, rows 4'b1111:
  - `cols` sequence 1110,1101,1011,0111,1110, each value held 2 cycles.
  - `WE_send` never asserts.
- Press row 0101-pattern equivalent 4'b1110 while `cols` = 4'b1101:
  - `WE_send` high for exactly one cycle, 5 cycles after the sample cycle.
  - During that cycle cols = 4'b1101 and synchrows = 4'b1110.
- Bounce: rows toggle 1110/1111 on alternate cycles during DEBOUNCE → no `WE_send`; `cols` stays 4'b1101 and the sequence re-enters SETTLE.
- Hold key 20 cycles, then release:
  - a single `WE_send` only.
  - `key_held` high until 4 all-high cycles elapse.
  - `cols` then rotates to 4'b1011.
- Chord: rows = 4'b1010 at a sample → no `WE_send`, `key_held` = 0; scanning resumes after 4 all-high cycles.
- Assert `reset` during WAIT_RELEASE → same cycle cols = 4'b1110, WE_send = 0, key_held = 0; after deassert, a normal scan resumes.
